// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: access size codes,
// controller state encoding and the alignment/legality check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // True when the size code is illegal or the byte offset is not aligned to it
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return (offset != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian byte-lane helper: merges store data into a memory word and
// extracts (with optional sign extension) a sub-word from a memory word.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_merged,
  output logic [31:0] o_extracted
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte lane and halfword lane out of the word
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  // Right-justify the selected lane and zero- or sign-extend it
  always_comb begin
    o_extracted = 32'h0;
    case (i_size)
      SZ_BYTE: o_extracted = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_extracted = {{16{i_signed & w_half[15]}}, w_half};
      SZ_WORD: o_extracted = i_word;
      default: o_extracted = 32'h0;
    endcase
  end

  // Replace only the addressed lanes of the old word with the store data
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        case (i_offset)
          2'd0: o_merged[7:0]   = i_data[7:0];
          2'd1: o_merged[15:8]  = i_data[7:0];
          2'd2: o_merged[23:16] = i_data[7:0];
          2'd3: o_merged[31:24] = i_data[7:0];
          default: o_merged = i_word;
        endcase
      end
      SZ_HALF: begin
        if (i_offset[1]) o_merged[31:16] = i_data[15:0];
        else             o_merged[15:0]  = i_data[15:0];
      end
      SZ_WORD: o_merged = i_data;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side controller for the 1024x32 data memory. Accepts byte/half/word
// loads and stores on a valid/ready handshake, does sub-word stores as a
// read-modify-write and returns extended sub-word load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t r_state;
  state_t w_nextState;

  logic              r_we;
  logic              r_signed;
  logic [1:0]        r_size;
  logic [1:0]        r_offset;
  logic [ADDR_W-1:0] r_wordAddr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;

  logic        w_bad;
  logic [31:0] w_laneWord;
  logic [31:0] w_merged;
  logic [31:0] w_extracted;

  assign w_bad      = is_bad_access(req_size, req_addr[1:0]);
  assign w_laneWord = (r_state == ST_RD) ? mem_dout : r_word;
  assign mem_addr   = r_wordAddr;

  mem_lane_merge u_laneMerge (
    .i_word      (w_laneWord),
    .i_data      (r_wdata),
    .i_offset    (r_offset),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .o_merged    (w_merged),
    .o_extracted (w_extracted)
  );

  // State register; reset returns to IDLE at once, which also drops mem_we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state decode and state-decoded handshake/memory outputs
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_we      = 1'b0;
    mem_din     = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_bad)                               w_nextState = ST_RESP;
          else if (req_we && req_size == SZ_WORD)  w_nextState = ST_WR;
          else                                     w_nextState = ST_RD;
        end
      end
      ST_RD:   w_nextState = r_we ? ST_WR : ST_RESP;
      ST_WR: begin
        mem_we      = 1'b1;
        mem_din     = w_merged;
        w_nextState = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Request latches, read-word capture and the response registers that hold until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= SZ_BYTE;
      r_offset   <= 2'b00;
      r_wordAddr <= '0;
      r_wdata    <= 32'h0;
      r_word     <= 32'h0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_we       <= req_we;
        r_signed   <= req_signed;
        r_size     <= req_size;
        r_offset   <= req_addr[1:0];
        r_wordAddr <= req_addr[ADDR_W+1:2];
        r_wdata    <= req_wdata;
        if (w_bad) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (r_state == ST_RD) begin
        r_word <= mem_dout;
        if (!r_we) begin
          rsp_rdata <= w_extracted;
          rsp_err   <= 1'b0;
        end
      end
      if (r_state == ST_WR) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a behavioural 1024x32 memory with
// combinational read, and a byte-addressed reference model of memory contents
// and expected responses.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] tbMem [1024];
  logic [7:0]  refBytes [4096];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_dout = tbMem[mem_addr];

  // Memory model: random initial contents mirrored into the reference, then synchronous writes
  initial begin
    for (int w = 0; w < 1024; w++) begin
      tbMem[w] = $urandom;
      for (int b = 0; b < 4; b++) refBytes[4*w+b] = tbMem[w][8*b +: 8];
    end
    forever begin
      @(posedge clk);
      if (mem_we) tbMem[mem_addr] <= mem_din;
    end
  end

  mem_access_unit #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  function automatic logic [31:0] refWord(input int idx);
    return {refBytes[4*idx+3], refBytes[4*idx+2], refBytes[4*idx+1], refBytes[4*idx]};
  endfunction

  // Reference: byte-array memory; returns expected data/err/latency/write count and updates memory on stores
  function automatic void modelAccess(input logic we, input logic [1:0] size, input logic sgn,
                                      input logic [11:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] expData, output logic expErr,
                                      output int expLat, output int expWes);
    int nBytes;
    longint val;
    nBytes  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
    expData = 32'h0;
    expErr  = 1'b0;
    expWes  = 0;
    expLat  = 0;
    if (nBytes == 0 || (int'(addr) % nBytes) != 0) begin
      expErr = 1'b1;
      expLat = 1;
    end else if (we) begin
      for (int i = 0; i < nBytes; i++) refBytes[int'(addr) + i] = wdata[8*i +: 8];
      expLat = (nBytes == 4) ? 2 : 3;
      expWes = 1;
    end else begin
      val = 0;
      for (int i = 0; i < nBytes; i++) val += longint'(refBytes[int'(addr) + i]) << (8*i);
      if (sgn && nBytes < 4 && val >= (longint'(1) << (8*nBytes - 1)))
        val -= (longint'(1) << (8*nBytes));
      expData = val[31:0];
      expLat  = 2;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one request, wait for acceptance and the response pulse, measuring latency and write cycles
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat,
                               output int weCycles, output logic [9:0] weAddr,
                               output logic timedOut, output int pulseLen);
    int guard;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    guard = 0; timedOut = 1'b0;
    lat = 0; weCycles = 0; weAddr = '0; rdata = '0; err = 1'b0; pulseLen = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) timedOut = 1'b1;
    while (!timedOut) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (mem_we) begin
        weCycles++;
        weAddr = mem_addr;
      end
      if (rsp_valid) begin
        rdata = rsp_rdata;
        err = rsp_err;
        pulseLen = 1;
        break;
      end
      if (lat >= 10) timedOut = 1'b1;
    end
    req_valid = 1'b0;
    if (!timedOut) begin
      @(negedge clk);
      if (rsp_valid) pulseLen++;
    end
  endtask

  task automatic doAccess(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output logic [9:0] weAddr);
    logic [31:0] expData;
    logic        expErr;
    logic        timedOut;
    int expLat, expWes, lat, wes, pulseLen;
    modelAccess(we, size, sgn, addr, wdata, expData, expErr, expLat, expWes);
    applyStimulus(we, size, sgn, addr, wdata, rdata, err, lat, wes, weAddr, timedOut, pulseLen);
    checkOutput({tag, " timeout"}, timedOut, 1'b0);
    checkOutput({tag, " rdata"}, rdata, expData);
    checkOutput({tag, " err"}, err, expErr);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " mem_we cycles"}, wes, expWes);
    checkOutput({tag, " pulse len"}, pulseLen, 1);
  endtask

  // Directed scenarios followed by randomized traffic against the reference model
  initial begin
    logic [31:0] rdata, hsExp;
    logic        err, hsErr;
    logic [9:0]  weAddr;
    logic        rWe, rSgn;
    logic [1:0]  rSize;
    logic [11:0] rAddr;
    int hsLat, hsWes, accepts, pulses, run, maxRun, overlap, mism;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset rsp_err", rsp_err, 1'b0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset mem_we", mem_we, 1'b0);
    checkOutput("reset mem_addr", mem_addr, 10'h0);
    checkOutput("reset mem_din", mem_din, 32'h0);
    checkOutput("reset req_ready", req_ready, 1'b1);
    rst_n = 1'b1;

    $display("[TB] reset during the write cycle of a word store");
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 12'h040; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midwr mem_we before reset", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midwr mem_we after reset", mem_we, 1'b0);
    checkOutput("midwr rsp_valid", rsp_valid, 1'b0);
    checkOutput("midwr mem_addr", mem_addr, 10'h0);
    checkOutput("midwr mem_din", mem_din, 32'h0);
    checkOutput("midwr rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("midwr rsp_err", rsp_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midwr req_ready", req_ready, 1'b1);
    checkOutput("midwr word unchanged", tbMem[16], refWord(16));

    $display("[TB] word path");
    doAccess("t2 store", 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, rdata, err, weAddr);
    doAccess("t2 load", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, rdata, err, weAddr);
    checkOutput("t2 load value", rdata, 32'hDEADBEEF);

    $display("[TB] byte read-modify-write");
    doAccess("t3 init", 1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344, rdata, err, weAddr);
    doAccess("t3 sb", 1'b1, 2'b00, 1'b0, 12'h013, 32'h000000A5, rdata, err, weAddr);
    checkOutput("t3 merged word", tbMem[4], 32'hA5223344);
    doAccess("t3 lb", 1'b0, 2'b00, 1'b1, 12'h013, 32'h0, rdata, err, weAddr);
    checkOutput("t3 lb value", rdata, 32'hFFFFFFA5);
    doAccess("t3 lbu", 1'b0, 2'b00, 1'b0, 12'h013, 32'h0, rdata, err, weAddr);
    checkOutput("t3 lbu value", rdata, 32'h000000A5);

    $display("[TB] halfword");
    doAccess("t4 sh", 1'b1, 2'b01, 1'b0, 12'h022, 32'h00008001, rdata, err, weAddr);
    doAccess("t4 lh", 1'b0, 2'b01, 1'b1, 12'h022, 32'h0, rdata, err, weAddr);
    checkOutput("t4 lh value", rdata, 32'hFFFF8001);
    doAccess("t4 misaligned", 1'b0, 2'b01, 1'b0, 12'h021, 32'h0, rdata, err, weAddr);
    checkOutput("t4 misaligned err", err, 1'b1);

    $display("[TB] continuous valid for four loads");
    modelAccess(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, hsExp, hsErr, hsLat, hsWes);
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 12'h010; req_valid = 1'b1;
    accepts = 0; pulses = 0; run = 0; maxRun = 0; overlap = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) begin
        pulses++;
        run++;
        checkOutput("hs rdata", rsp_rdata, hsExp);
      end else begin
        run = 0;
      end
      if (run > maxRun) maxRun = run;
      if (req_ready && rsp_valid) overlap++;
      if (req_valid && req_ready) accepts++;
      else if (accepts == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("hs accepts", accepts, 4);
    checkOutput("hs pulses", pulses, 4);
    checkOutput("hs pulse width", maxRun, 1);
    checkOutput("hs ready during resp", overlap, 0);

    $display("[TB] address wrap and illegal size");
    doAccess("t6 top word", 1'b1, 2'b10, 1'b0, 12'hFFC, 32'h0BADF00D, rdata, err, weAddr);
    checkOutput("t6 mem_addr", weAddr, 10'h3FF);
    checkOutput("t6 top word mem", tbMem[1023], 32'h0BADF00D);
    doAccess("t6 illegal", 1'b1, 2'b11, 1'b0, 12'h010, 32'h12345678, rdata, err, weAddr);
    checkOutput("t6 illegal err", err, 1'b1);
    checkOutput("t6 memory untouched", tbMem[4], refWord(4));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      rWe   = 1'($urandom_range(0, 1));
      rSgn  = 1'($urandom_range(0, 1));
      rSize = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rAddr = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 63));
      doAccess($sformatf("rnd%0d", i), rWe, rSize, rSgn, rAddr, $urandom, rdata, err, weAddr);
    end

    mism = 0;
    for (int w = 0; w < 1024; w++) if (tbMem[w] !== refWord(w)) mism++;
    checkOutput("final memory sweep mismatches", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
